// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, RV32I opcodes,
// the canonical NOP and instruction field positions.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int OPCODE_LSB  = 0;
    localparam int OPCODE_MSB  = 6;
    localparam int FUNCT3_LSB  = 12;
    localparam int FUNCT3_MSB  = 14;
    localparam int FUNCT75_BIT = 30;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instr} FIFO between instruction memory and decode.
module fetch_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_instr,
    input  logic              pop,
    output logic [DATA_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_instr,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] pc_mem    [2];
    logic [DATA_W-1:0] instr_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, two-entry
// instruction buffer, redirect handling with stale-response discard.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct75
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  wait_pc;
    logic [31:0]  hold_pc;
    logic [31:0]  head_pc;
    logic [31:0]  head_instr;
    logic [1:0]   count;
    logic         req_fire;
    logic         rsp_push;
    logic         pop;

    // Outstanding count is zero in F_REQ, so the buffer occupancy alone gates issue.
    assign imem_req_valid = !rst && (state == F_REQ) && (count < 2'd2) && !redirect;
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_push       = (state == F_WAIT) && imem_rsp_valid && !redirect;
    assign if_valid       = (count != 2'd0);
    assign pop            = if_valid && if_ready && !redirect;

    fetch_buffer #(
        .DATA_W(32)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (rsp_push),
        .push_pc    (wait_pc),
        .push_instr (imem_rsp_data),
        .pop        (pop),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= F_REQ;
            fetch_pc <= word_align(RESET_PC);
            hold_pc  <= 32'h0000_0000;
        end else begin
            if (redirect)      fetch_pc <= word_align(redirect_target);
            else if (req_fire) fetch_pc <= fetch_pc + 32'd4;

            if (if_valid) hold_pc <= head_pc;

            case (state)
                F_REQ: begin
                    if (req_fire) state <= F_WAIT;
                end
                F_WAIT: begin
                    if (imem_rsp_valid) state <= F_REQ;
                    else if (redirect)  state <= F_DROP;
                end
                F_DROP: begin
                    if (imem_rsp_valid) state <= F_REQ;
                end
                default: state <= F_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) wait_pc <= fetch_pc;
    end

    // When empty, decode sees a NOP tagged with the last presented address.
    assign if_instr    = if_valid ? head_instr : NOP_INSTR;
    assign if_pc       = if_valid ? head_pc : hold_pc;
    assign if_pc_plus4 = if_pc + 32'd4;
    assign opcode      = if_instr[OPCODE_MSB:OPCODE_LSB];
    assign funct3      = if_instr[FUNCT3_MSB:FUNCT3_LSB];
    assign funct75     = if_instr[FUNCT75_BIT];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a fixed-latency instruction memory model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct75;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int cnt;
    logic [31:0] pend_addr;
    logic [31:0] req_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_ins_q[$];

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .opcode          (opcode),
        .funct3          (funct3),
        .funct75         (funct75)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0200: return 32'h0020_8233;
            32'h0000_0204: return 32'h4020_8233;
            default:       return 32'h1000_0000 | a;
        endcase
    endfunction

    // Memory: response valid exactly lat cycles after acceptance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 0;
        end else if (imem_req_valid && imem_req_ready) begin
            cnt       <= lat;
            pend_addr <= imem_addr;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end
    assign imem_rsp_valid = (cnt == 1);
    assign imem_rsp_data  = mem_word(pend_addr);

    always @(negedge clk) begin
        if (imem_req_valid && imem_req_ready) req_q.push_back(imem_addr);
        if (if_valid && if_ready) begin
            pop_pc_q.push_back(if_pc);
            pop_ins_q.push_back(if_instr);
        end
    end

    task automatic do_reset(input int latency, input logic rdy);
        rst      = 1'b1;
        redirect = 1'b0;
        lat      = latency;
        if_ready = rdy;
        repeat (2) @(posedge clk);
        #1;
        req_q.delete();
        pop_pc_q.delete();
        pop_ins_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lat = 1;
        repeat (2) @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
        checks++; if (if_instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_if_instr: got %h expected 00000013", if_instr); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h expected 00000000", if_pc); end
        checks++; if (if_pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h expected 00000004", if_pc_plus4); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req: got valid=%b addr=%h expected valid=1 addr=00000000", imem_req_valid, imem_addr); end
    endtask

    task automatic test_sequential();
        do_reset(1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL seq_latency_early: got if_valid=%b expected 0", if_valid); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h1000_0000 || if_pc_plus4 !== 32'h4) begin
            errors++; $display("FAIL seq_first_instr: got v=%b pc=%h instr=%h p4=%h expected v=1 pc=00000000 instr=10000000 p4=00000004", if_valid, if_pc, if_instr, if_pc_plus4);
        end
        repeat (6) @(negedge clk);
        checks++; if (req_q.size() < 3 || pop_pc_q.size() < 3) begin errors++; $display("FAIL seq_counts: got reqs=%0d pops=%0d expected >=3 each", req_q.size(), pop_pc_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (req_q[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_req_addr[%0d]: got %h expected %h", i, req_q[i], 32'(4 * i)); end
            checks++; if (pop_pc_q[i] !== 32'(4 * i) || pop_ins_q[i] !== (32'h1000_0000 | 32'(4 * i))) begin
                errors++; $display("FAIL seq_pop[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", i, pop_pc_q[i], pop_ins_q[i], 32'(4 * i), 32'h1000_0000 | 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (if_valid !== 1'b1 || imem_req_valid !== 1'b0 || if_pc !== 32'h0) begin
            errors++; $display("FAIL bp_stall: got v=%b req=%b pc=%h expected v=1 req=0 pc=00000000", if_valid, imem_req_valid, if_pc);
        end
        checks++; if (req_q.size() != 2 || dut.count !== 2'd2) begin errors++; $display("FAIL bp_occupancy: got reqs=%0d count=%0d expected 2 and 2", req_q.size(), dut.count); end
        @(posedge clk); #1;
        if_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (pop_pc_q.size() < 2) begin errors++; $display("FAIL bp_drain_count: got %0d expected >=2", pop_pc_q.size()); end
        checks++; if (pop_pc_q[0] !== 32'h0 || pop_ins_q[0] !== 32'h1000_0000) begin errors++; $display("FAIL bp_drain0: got pc=%h instr=%h expected 00000000 10000000", pop_pc_q[0], pop_ins_q[0]); end
        checks++; if (pop_pc_q[1] !== 32'h4 || pop_ins_q[1] !== 32'h1000_0004) begin errors++; $display("FAIL bp_drain1: got pc=%h instr=%h expected 00000004 10000004", pop_pc_q[1], pop_ins_q[1]); end
    endtask

    task automatic test_redirect_wait();
        int n;
        do_reset(3, 1'b1);
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rw_first_req: got v=%b addr=%h expected 1 00000000", imem_req_valid, imem_addr); end
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_target = 32'h0000_0103;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_req_in_redirect: got %b expected 0", imem_req_valid); end
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (dut.state !== F_DROP || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_drop_state: got state=%0d req=%b expected state=2 req=0", dut.state, imem_req_valid); end
        @(negedge clk);
        checks++; if (imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_rsp: got rsp=%b req=%b expected rsp=1 req=0", imem_rsp_valid, imem_req_valid); end
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0100 || if_valid !== 1'b0) begin
            errors++; $display("FAIL rw_new_req: got req=%b addr=%h if_valid=%b expected 1 00000100 0", imem_req_valid, imem_addr, if_valid);
        end
        n = 0;
        while (!if_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL rw_new_latency: got %0d cycles expected 4", n); end
        checks++; if (if_pc !== 32'h0000_0100 || if_instr !== 32'h1000_0100) begin errors++; $display("FAIL rw_new_word: got pc=%h instr=%h expected 00000100 10000100", if_pc, if_instr); end
        @(negedge clk);
        checks++; if (pop_pc_q.size() < 1 || pop_pc_q[0] !== 32'h0000_0100) begin errors++; $display("FAIL rw_stale_pushed: got first popped pc=%h expected 00000100", pop_pc_q[0]); end
    endtask

    task automatic test_redirect_rsp_decode();
        do_reset(1, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_target = 32'h0000_0200;
        @(negedge clk);
        checks++; if (imem_rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_coincident_rsp: got %b expected 1", imem_rsp_valid); end
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || dut.count !== 2'd0 || dut.state !== F_REQ) begin
            errors++; $display("FAIL rr_discard: got v=%b count=%0d state=%0d expected 0 0 0", if_valid, dut.count, dut.state);
        end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0200) begin errors++; $display("FAIL rr_next_req: got v=%b addr=%h expected 1 00000200", imem_req_valid, imem_addr); end
        repeat (4) @(negedge clk);
        checks++; if (if_pc !== 32'h0000_0200 || if_instr !== 32'h0020_8233) begin errors++; $display("FAIL dec_add_word: got pc=%h instr=%h expected 00000200 00208233", if_pc, if_instr); end
        checks++; if (opcode !== 7'b0110011 || funct3 !== 3'b000 || funct75 !== 1'b0) begin
            errors++; $display("FAIL dec_add_fields: got op=%b f3=%b f75=%b expected 0110011 000 0", opcode, funct3, funct75);
        end
        @(posedge clk); #1;
        if_ready = 1'b1;
        @(posedge clk); #1;
        if_ready = 1'b0;
        @(negedge clk);
        checks++; if (if_pc !== 32'h0000_0204 || if_instr !== 32'h4020_8233) begin errors++; $display("FAIL dec_sub_word: got pc=%h instr=%h expected 00000204 40208233", if_pc, if_instr); end
        checks++; if (opcode !== 7'b0110011 || funct3 !== 3'b000 || funct75 !== 1'b1) begin
            errors++; $display("FAIL dec_sub_fields: got op=%b f3=%b f75=%b expected 0110011 000 1", opcode, funct3, funct75);
        end
    endtask

    task automatic test_wrap_hold();
        rst = 1'b1;
        lat = 1;
        if_ready = 1'b0;
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_redirect_req: got %b expected 0", imem_req_valid); end
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req_top: got v=%b addr=%h expected 1 fffffffc", imem_req_valid, imem_addr); end
        repeat (2) @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0 || if_instr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_instr: got v=%b pc=%h p4=%h instr=%h expected 1 fffffffc 00000000 fffffffc", if_valid, if_pc, if_pc_plus4, if_instr);
        end
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got v=%b addr=%h expected 1 00000000", imem_req_valid, imem_addr); end
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_target = 32'h0000_0300;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0000_0013 || if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin
            errors++; $display("FAIL hold_empty: got v=%b instr=%h pc=%h p4=%h expected 0 00000013 fffffffc 00000000", if_valid, if_instr, if_pc, if_pc_plus4);
        end
        checks++; if (imem_addr !== 32'h0000_0300) begin errors++; $display("FAIL hold_redirect_addr: got %h expected 00000300", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp_decode();
        test_wrap_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the value presented on if_instr when the buffer is empty.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts the request.
REQ-007 imem_addr  output  32  fetch address, always word-aligned.
REQ-008 imem_rsp_valid  input  1  instruction word returned; at most one per accepted request, in order, latency >= 1 cycle.
REQ-009 imem_rsp_data  input  32  returned instruction word.
REQ-010 redirect  input  1  taken branch/jump (PCSrc from decode/control).
REQ-011 redirect_target  input  32  new PC on redirect.
REQ-012 if_valid  output  1  an instruction is presented to decode.
REQ-013 if_ready  input  1  decode consumes the presented instruction.
REQ-014 if_instr  output  32  instruction word.
REQ-015 if_pc  output  32  address of if_instr.
REQ-016 if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
REQ-017 opcode  output  7  SHALL equal if_instr[6:0].
REQ-018 funct3  output  3  SHALL equal if_instr[14:12].
REQ-019 funct75  output  1  SHALL equal if_instr[30].

Function
REQ-020 Request handshake: a request SHALL transfer when imem_req_valid and imem_req_ready are both high; imem_addr SHALL stay stable while imem_req_valid is high without ready, unless a redirect occurs.
REQ-021 At most one request SHALL be outstanding; FSM states: F_REQ (drive request), F_WAIT (await response), F_DROP (await and discard one stale response).
REQ-022 F_REQ: imem_req_valid = (buffer count + 0) < 2 and no redirect this cycle; on acceptance, fetch_pc SHALL advance by 4 (wrapping 32'hFFFF_FFFC -> 0) and FSM SHALL go to F_WAIT.
REQ-023 F_WAIT: on imem_rsp_valid, {fetch address, imem_rsp_data} SHALL be pushed into the buffer in the same edge and FSM SHALL go to F_REQ.
REQ-024 Buffer: 2-entry FIFO of {pc, instr}; a request SHALL only issue when count + outstanding < 2, so the FIFO never overflows and never back-pressures the memory.
REQ-025 Output: if_valid = (count != 0); head entry drives if_instr/if_pc; pop when if_valid and if_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-026 Latency: from request acceptance, a 1-cycle memory response SHALL appear on if_valid the cycle after the response cycle; sustained throughput with if_ready high SHALL be one instruction per 2 cycles minimum.
REQ-027 Redirect (highest priority): in the redirect cycle the FIFO SHALL be flushed, fetch_pc SHALL load {redirect_target[31:2], 2'b00}, imem_req_valid SHALL be low, and if_ready pops SHALL be ignored.
REQ-028 Redirect while F_WAIT without a response that cycle SHALL go to F_DROP; redirect coincident with a response SHALL discard that response and go to F_REQ.
REQ-029 Redirect in F_REQ SHALL stay in F_REQ (no request can be accepted that cycle); redirect in F_DROP SHALL remain in F_DROP unless the stale response arrives that cycle (then F_REQ).
REQ-030 F_DROP: the next imem_rsp_valid SHALL be discarded without a push; FSM SHALL then go to F_REQ.
REQ-031 When empty, if_instr SHALL equal NOP_INSTR, if_pc and if_pc_plus4 SHALL hold the last head values (0 and 4 after reset).

Reset
REQ-032 On rst: fetch_pc = RESET_PC, state = F_REQ, FIFO count = 0, pointers = 0, if_valid = 0, if_instr = NOP_INSTR, if_pc = 0, imem_req_valid = 0 while rst is high.
REQ-033 Reset asserted mid-transaction SHALL abandon the outstanding request; the memory model SHALL also be reset, so no stale response is expected afterwards.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, RISC-V opcode constants, NOP_INSTR and the instruction field bit positions.
REQ-035 The 2-entry {pc, instr} FIFO SHALL be a sub-module named fetch_buffer (count, flush, push, pop ports); all other logic stays in fetch_unit.

Verification
REQ-036 Reset release, 1-cycle memory, if_ready=1 -> requests at 0x0, 0x4, 0x8; if_pc sequence 0x0, 0x4, 0x8 with matching words.
REQ-037 if_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req_valid low, no response lost; if_ready=1 -> both drained in order.
REQ-038 Redirect to 0x0000_0103 while F_WAIT (3-cycle memory) -> stale word discarded, next imem_addr = 0x0000_0100, if_valid low until the new word returns.
REQ-039 Redirect in the same cycle as a response -> response not pushed, FIFO empty, FSM in F_REQ.
REQ-040 fetch_pc = 0xFFFF_FFFC accepted -> next imem_addr = 0x0000_0000, if_pc_plus4 = 0x0000_0000 for that instruction.
REQ-041 Word 0x0020_8233 (add) presented -> opcode = 7'b0110011, funct3 = 3'b000, funct75 = 0; word 0x4020_8233 (sub) -> funct75 = 1.
